// File: rtl/top_pwm.sv
// -----------------------------------------------------------------------------
// top_pwm -- servo PWM generator for an MG995-class hobby servo.
//
// Generates a fixed frame of PERIOD_CYC clocks (20 ms at 50 MHz). The high
// time is picked by a 2-bit angle select: off / 0.5 ms / 1.5 ms / 2.5 ms.
// The select is synchronised, then sampled only at frame start, so a switch
// change mid-frame never produces a runt or stretched pulse.
//
// Optional feature (macro PWM_UART_REPORT_EN):
//   defined   -> every change of the applied select is sent as one ASCII byte
//                ('0'..'3') on Tx_o, UART 8N1, CLKS_PER_BIT clocks per bit,
//                with a one-deep "latest value wins" pending slot.
//   undefined -> no UART logic, Tx_o tied high (idle). PWM is unchanged.
//
// Ports:
//   Clk_i    in   1  system clock, rising edge
//   Reset_i  in   1  asynchronous active-low reset
//   Sel_i    in   2  angle select from board switches (asynchronous)
//   Pwm_o    out  1  servo PWM, registered
//   Tx_o     out  1  UART serial out, idle high, registered
// -----------------------------------------------------------------------------
module top_pwm #(
    parameter int CLK_HZ     = 50_000_000,
    parameter int PERIOD_CYC = CLK_HZ / 50,            // 20 ms
    parameter int DUTY1_CYC  = CLK_HZ / 2000,          // 0.5 ms
    parameter int DUTY2_CYC  = (CLK_HZ / 2000) * 3,    // 1.5 ms
    parameter int DUTY3_CYC  = (CLK_HZ / 2000) * 5     // 2.5 ms
`ifdef PWM_UART_REPORT_EN
    ,
    parameter int CLKS_PER_BIT = CLK_HZ / 115_200      // 115200 baud
`endif
) (
    input  logic       Clk_i,
    input  logic       Reset_i,
    input  logic [1:0] Sel_i,
    output logic       Pwm_o,
    output logic       Tx_o
);

    localparam int               CNT_W    = $clog2(PERIOD_CYC);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PERIOD_CYC - 1);
    localparam logic [CNT_W-1:0] DUTY1    = CNT_W'(DUTY1_CYC);
    localparam logic [CNT_W-1:0] DUTY2    = CNT_W'(DUTY2_CYC);
    localparam logic [CNT_W-1:0] DUTY3    = CNT_W'(DUTY3_CYC);

    logic [1:0]       r_sel_meta;
    logic [1:0]       r_sel_sync;
    logic [CNT_W-1:0] r_cnt;
    logic [1:0]       r_sel_app;
    logic             r_pwm;
    logic             w_frame_start;
    logic [1:0]       w_sel_cur;
    logic [CNT_W-1:0] w_duty;

    // NOTE: the synchroniser flops are intentionally left without reset so they
    // keep tracking the switches while reset is held; the first frame after
    // release therefore already uses the real switch setting.
    always_ff @(posedge Clk_i) begin
        r_sel_meta <= Sel_i;
        r_sel_sync <= r_sel_meta;
    end

    assign w_frame_start = (r_cnt == '0);

    // At frame start the freshly latched select must already drive the first
    // compare, otherwise the first cycle of the frame would use the old duty.
    assign w_sel_cur = w_frame_start ? r_sel_sync : r_sel_app;

    always_comb begin
        // NOTE: default assignment first so every path drives w_duty and no
        // latch is inferred.
        w_duty = '0;
        case (w_sel_cur)
            2'd1:    w_duty = DUTY1;
            2'd2:    w_duty = DUTY2;
            2'd3:    w_duty = DUTY3;
            default: w_duty = '0;
        endcase
    end

    // NOTE: non-blocking assignments so every register samples the values that
    // existed before the clock edge, independent of statement order.
    always_ff @(posedge Clk_i or negedge Reset_i) begin
        if (!Reset_i) begin
            r_cnt     <= '0;
            r_sel_app <= '0;
            r_pwm     <= 1'b0;
        end else begin
            r_cnt <= (r_cnt == CNT_LAST) ? '0 : r_cnt + 1'b1;
            if (w_frame_start) begin
                r_sel_app <= r_sel_sync;
            end
            r_pwm <= (r_cnt < w_duty);
        end
    end

    assign Pwm_o = r_pwm;

`ifdef PWM_UART_REPORT_EN
    localparam int               BIT_W    = $clog2(CLKS_PER_BIT);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_state_t;

    tx_state_t        r_state;
    logic [BIT_W-1:0] r_clk_cnt;
    logic [2:0]       r_bit_idx;
    logic [7:0]       r_shift;
    logic             r_tx;
    logic             r_pend_vld;
    logic [1:0]       r_pend_sel;
    logic             w_report;

    // A report is due when the select latched at this frame start differs
    // from the one applied during the previous frame.
    assign w_report = w_frame_start && (r_sel_sync != r_sel_app);

    always_ff @(posedge Clk_i or negedge Reset_i) begin
        if (!Reset_i) begin
            r_state    <= TX_IDLE;
            r_clk_cnt  <= '0;
            r_bit_idx  <= '0;
            r_shift    <= '0;
            r_tx       <= 1'b1;
            r_pend_vld <= 1'b0;
            r_pend_sel <= '0;
        end else begin
            case (r_state)
                TX_IDLE: begin
                    if (r_pend_vld) begin
                        r_state    <= TX_START;
                        r_tx       <= 1'b0;
                        r_clk_cnt  <= '0;
                        r_shift    <= {6'b0011_00, r_pend_sel};   // ASCII '0'..'3'
                        r_pend_vld <= 1'b0;
                    end
                end
                TX_START: begin
                    if (r_clk_cnt == BIT_LAST) begin
                        r_clk_cnt <= '0;
                        r_bit_idx <= '0;
                        r_state   <= TX_DATA;
                        r_tx      <= r_shift[0];
                    end else begin
                        r_clk_cnt <= r_clk_cnt + 1'b1;
                    end
                end
                TX_DATA: begin
                    if (r_clk_cnt == BIT_LAST) begin
                        r_clk_cnt <= '0;
                        if (r_bit_idx == 3'd7) begin
                            r_state <= TX_STOP;
                            r_tx    <= 1'b1;
                        end else begin
                            r_bit_idx <= r_bit_idx + 1'b1;
                            r_shift   <= {1'b0, r_shift[7:1]};
                            r_tx      <= r_shift[1];
                        end
                    end else begin
                        r_clk_cnt <= r_clk_cnt + 1'b1;
                    end
                end
                TX_STOP: begin
                    if (r_clk_cnt == BIT_LAST) begin
                        r_clk_cnt <= '0;
                        // A pending report goes out back-to-back with no idle gap.
                        if (r_pend_vld) begin
                            r_state    <= TX_START;
                            r_tx       <= 1'b0;
                            r_shift    <= {6'b0011_00, r_pend_sel};
                            r_pend_vld <= 1'b0;
                        end else begin
                            r_state <= TX_IDLE;
                        end
                    end else begin
                        r_clk_cnt <= r_clk_cnt + 1'b1;
                    end
                end
                default: r_state <= TX_IDLE;
            endcase

            // Placed after the FSM so a new report overrides a slot consumed on
            // the same edge; a newer value also overwrites an unsent one.
            if (w_report) begin
                r_pend_vld <= 1'b1;
                r_pend_sel <= r_sel_sync;
            end
        end
    end

    assign Tx_o = r_tx;
`else
    assign Tx_o = 1'b1;
`endif

endmodule

// File: tb/tb_top_pwm.sv
// -----------------------------------------------------------------------------
// tb_top_pwm -- self-checking bench for top_pwm with a shortened frame.
// A frame-level reference model predicts the PWM waveform from the select
// present at each frame start, and a queue model predicts the UART byte
// stream (one-deep pending slot, latest value wins). A UART receiver decodes
// Tx_o and checks bit timing. Works with and without PWM_UART_REPORT_EN.
// -----------------------------------------------------------------------------
module tb_top_pwm;

    localparam int P   = 400;
    localparam int D1  = 20;
    localparam int D2  = 60;
    localparam int D3  = 100;
    localparam int CPB = 100;
`ifdef PWM_UART_REPORT_EN
    localparam int TX_IN_START = 0;
`else
    localparam int TX_IN_START = 1;
`endif

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] sel   = 2'd3;
    logic       pwm;
    logic       tx;

    top_pwm #(
        .PERIOD_CYC (P),
        .DUTY1_CYC  (D1),
        .DUTY2_CYC  (D2),
        .DUTY3_CYC  (D3)
`ifdef PWM_UART_REPORT_EN
        ,
        .CLKS_PER_BIT (CPB)
`endif
    ) dut (
        .Clk_i   (clk),
        .Reset_i (rst_n),
        .Sel_i   (sel),
        .Pwm_o   (pwm),
        .Tx_o    (tx)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int duty_of(input logic [1:0] s);
        case (s)
            2'd1:    return D1;
            2'd2:    return D2;
            2'd3:    return D3;
            default: return 0;
        endcase
    endfunction

    // ---------------- reference model ----------------
    int          n          = 0;     // clock edges since reset release
    logic [1:0]  m_sel      = 2'd0;  // select applied in the current frame
    logic [1:0]  m_prev     = 2'd0;  // select applied in the previous frame
    bit          exp_pwm    = 1'b0;
    bit          f_valid    = 1'b0;
    int          f_err      = 0;
    int          f_high     = 0;
    int          busy_until = 0;     // edge at which the transmitter frees up
    bit          m_pend_vld = 1'b0;
    logic [1:0]  m_pend     = 2'd0;
    logic [7:0]  exp_q[$];
    logic [7:0]  rx_q[$];

    always @(posedge clk) begin
        if (!rst_n) begin
`ifdef PWM_UART_REPORT_EN
            // A byte still on the wire when reset hits is never completed.
            if (n > 0 && n < busy_until && exp_q.size() > 0) exp_q.pop_back();
`endif
            n          = 0;
            f_valid    = 1'b0;
            m_prev     = 2'd0;
            m_pend_vld = 1'b0;
            busy_until = 0;
            exp_pwm    = 1'b0;
        end else begin
            n++;
`ifdef PWM_UART_REPORT_EN
            if (m_pend_vld && n == busy_until) begin
                exp_q.push_back({6'b0011_00, m_pend});
                m_pend_vld = 1'b0;
                busy_until = n + 10 * CPB;
            end
`endif
            if ((n - 1) % P == 0) begin
                if (f_valid) begin
                    check("frame_pwm_errors", f_err, 0);
                    check("frame_high_time", f_high, duty_of(m_sel));
                end
                f_valid = 1'b1;
                f_err   = 0;
                f_high  = 0;
                m_sel   = sel;
`ifdef PWM_UART_REPORT_EN
                if (m_sel != m_prev) begin
                    if (n >= busy_until && !m_pend_vld) begin
                        exp_q.push_back({6'b0011_00, m_sel});
                        busy_until = n + 1 + 10 * CPB;
                    end else begin
                        m_pend_vld = 1'b1;
                        m_pend     = m_sel;
                    end
                end
`endif
                m_prev = m_sel;
            end
            exp_pwm = ((n - 1) % P) < duty_of(m_sel);
        end
    end

    always @(negedge clk) begin
        if (rst_n && n > 0) begin
            if (pwm !== exp_pwm) f_err++;
            if (pwm === 1'b1) f_high++;
        end
    end

    // ---------------- UART receiver ----------------
    bit         rx_busy = 1'b0;
    int         rx_i    = 0;
    int         rx_err  = 0;
    int         rx_k    = 0;
    logic       rx_bit  = 1'b1;
    logic [7:0] rx_byte = 8'h00;

    always @(negedge clk) begin
        if (!rst_n) begin
            rx_busy = 1'b0;
        end else begin
            if (!rx_busy && tx === 1'b0) begin
                rx_busy = 1'b1;
                rx_i    = 0;
                rx_err  = 0;
            end
            if (rx_busy) begin
                rx_k = rx_i / CPB;
                if (rx_i % CPB == 0) rx_bit = tx;
                else if (tx !== rx_bit) rx_err++;      // bit not held for CPB clocks
                if (rx_i % CPB == CPB - 1) begin
                    if (rx_k == 0) begin
                        if (rx_bit !== 1'b0) rx_err++;
                    end else if (rx_k <= 8) begin
                        rx_byte[rx_k-1] = rx_bit;
                    end else begin
                        if (rx_bit !== 1'b1) rx_err++;
                        rx_q.push_back(rx_byte);
                        check("uart_frame_errors", rx_err, 0);
                        rx_busy = 1'b0;
                    end
                end
                rx_i++;
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic wait_phase(input int ph);
        bit found;
        found = 1'b0;
        for (int i = 0; i < 2 * P + 4; i++) begin
            @(negedge clk);
            if (rst_n && n > 0 && (n - 1) % P == ph) begin
                found = 1'b1;
                break;
            end
        end
        if (!found) check("phase_reached", (n - 1) % P, ph);
    endtask

    task automatic measure_frame(output int high);
        wait_phase(0);
        high = int'(pwm);
        repeat (P - 1) begin
            @(negedge clk);
            high += int'(pwm);
        end
    endtask

    task automatic wait_rise(output int at);
        logic prev;
        prev = pwm;
        at   = -1;
        for (int i = 0; i < 2 * P + 4; i++) begin
            @(negedge clk);
            if (pwm === 1'b1 && prev === 1'b0) begin
                at = n;
                break;
            end
            prev = pwm;
        end
        if (at < 0) check("rise_seen", at, 0);
    endtask

    typedef struct {
        logic [1:0] sel_a;      // first change in the frame
        logic [1:0] sel_b;      // second change, present at next frame start
        int         exp_high;   // high time of the following frame
    } vec_t;

    vec_t vecs[8];

    initial begin
        #800_000;
        $display("FAIL watchdog: bench did not finish, got t=%0t, expected end before 800000", $time);
        $fatal(1);
    end

    initial begin
        int h;
        int r1;
        int r2;
        int rx0;
        int nmin;

        vecs[0] = '{2'd1, 2'd1, D1};
        vecs[1] = '{2'd2, 2'd2, D2};
        vecs[2] = '{2'd0, 2'd0, 0};
        vecs[3] = '{2'd3, 2'd2, D2};
        vecs[4] = '{2'd1, 2'd3, D3};
        vecs[5] = '{2'd2, 2'd0, 0};
        vecs[6] = '{2'd0, 2'd2, D2};
        vecs[7] = '{2'd3, 2'd3, D3};

        // Reset state, then release with Sel=3.
        rst_n = 1'b0;
        sel   = 2'd3;
        repeat (10) @(negedge clk);
        check("reset_pwm", int'(pwm), 0);
        check("reset_tx", int'(tx), 1);
        rst_n = 1'b1;

        measure_frame(h);
        check("first_frame_high", h, D3);
        wait_rise(r1);
        wait_rise(r2);
        check("rise_spacing", r2 - r1, P);

        // Table: two changes per frame, the later one is applied next frame.
        for (int v = 0; v < 8; v++) begin
            wait_phase(100);
            sel = vecs[v].sel_a;
            wait_phase(250);
            sel = vecs[v].sel_b;
            measure_frame(h);
            check($sformatf("vec%0d_high", v), h, vecs[v].exp_high);
        end

        // Reports in consecutive frames while busy: latest pending value wins.
        repeat (6 * P) @(negedge clk);
        rx0 = rx_q.size();
        wait_phase(100); sel = 2'd1;
        wait_phase(100); sel = 2'd2;
        wait_phase(100); sel = 2'd0;
        repeat (3000) @(negedge clk);
`ifdef PWM_UART_REPORT_EN
        check("latest_wins_count", rx_q.size() - rx0, 2);
        if (rx_q.size() >= rx0 + 2) begin
            check("latest_wins_first", int'(rx_q[rx0]), 8'h31);
            check("latest_wins_second", int'(rx_q[rx0+1]), 8'h30);
        end
`else
        check("no_uart_bytes", rx_q.size() - rx0, 0);
`endif

        // Randomised select changes kept clear of the frame boundary.
        for (int r = 0; r < 20; r++) begin
            wait_phase(int'($urandom_range(150, 10)));
            sel = 2'($urandom_range(3, 0));
            if ($urandom_range(1, 0) == 1) begin
                wait_phase(int'($urandom_range(P - 10, 200)));
                sel = 2'($urandom_range(3, 0));
            end
        end

        // Reset in the middle of a pulse and of a start bit.
        wait_phase(100);
        sel = 2'd0;
        repeat (6 * P) @(negedge clk);
        wait_phase(100);
        sel = 2'd3;
        wait_phase(50);
        check("pre_reset_pwm", int'(pwm), 1);
        check("pre_reset_tx", int'(tx), TX_IN_START);
        #2 rst_n = 1'b0;
        #1;
        check("reset_mid_pwm", int'(pwm), 0);
        check("reset_mid_tx", int'(tx), 1);
        repeat (10) @(negedge clk);
        rst_n = 1'b1;
        measure_frame(h);
        check("post_reset_high", h, D3);

        // Drain the transmitter and compare the whole byte stream.
        repeat (2500) @(negedge clk);
        check("uart_byte_count", rx_q.size(), exp_q.size());
        nmin = (rx_q.size() < exp_q.size()) ? rx_q.size() : exp_q.size();
        for (int i = 0; i < nmin; i++) begin
            check($sformatf("uart_byte%0d", i), int'(rx_q[i]), int'(exp_q[i]));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
